d_debounce_edge: RTL
====================

# d_debounce_edge

Debounce and edge-detect stage directly downstream of the posedge D flip-flop. It consumes the registered `q` of that flop on `d_in` and filters out pulses shorter than `STABLE_CYCLES` clocks. It publishes a clean level plus single-cycle rise/fall strobes, and optionally keeps a saturating count of accepted rising edges.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a level change. Legal range is ≥2.
- `CNT_W`, default 8: width of `edge_count`.
- `clk`  input  1  clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `d_in`  input  1  level from the upstream D flip-flop `q`; already registered in the `clk` domain.
- `q_stable`  output  1  debounced level.
- `rise`  output  1  one-cycle strobe on an accepted 0→1 change.
- `fall`  output  1  one-cycle strobe on an accepted 1→0 change.
- `edge_count`  output  CNT_W  accepted rising edges, saturating.

Clocking and reset:
- One clock, `clk`.
- Reset `rst` is synchronous and active-high.

## Operation
- The FSM has four states: `ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`.
- The run counter `run_cnt` is $clog2(STABLE_CYCLES+1) bits wide.
- `ST_LOW`:
  - `d_in`=1 → `CHK_HIGH`, `run_cnt`=1.
  - Otherwise stay.
- `CHK_HIGH`:
  - `d_in`=0 → `ST_LOW`, `run_cnt`=0. This is a glitch: no strobe, `q_stable` unchanged.
  - `d_in`=1 and `run_cnt`==STABLE_CYCLES-1 → `ST_HIGH`, `q_stable`←1, `rise`←1, `run_cnt`=0.
  - `d_in`=1 otherwise → `run_cnt`+1.
- `ST_HIGH` and `CHK_LOW` mirror `ST_LOW` and `CHK_HIGH` with polarity inverted. Acceptance in `CHK_LOW` asserts `fall` and drives `q_stable`←0.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- `edge_count` increments by 1 in the same cycle `rise` is asserted. It holds at 2^CNT_W-1 once reached; there is no wrap.

## Timing
- Reset values: `q_stable`=0, `rise`=0, `fall`=0, `edge_count`=0, state=`ST_LOW`, `run_cnt`=0.
- Latency:
  - If `d_in` is first sampled at its new value on edge k and held, `q_stable`/`rise` update on edge k+STABLE_CYCLES-1.
  - With default 4: k+3, i.e. 3 clocks after first sample.
- Minimum accepted pulse is STABLE_CYCLES clocks. A pulse of STABLE_CYCLES-1 clocks produces no output change.
- A toggle on the sample that would have completed acceptance aborts the check. The new value then restarts from `ST_*` on the next edge.
- Reset mid-check aborts the check, with no strobe. Reset has priority over every transition and over the `edge_count` increment.
- `rise` on a cycle where `edge_count` is saturated: the strobe still fires; the count holds.
- `d_in` is assumed synchronous to `clk` (it comes from the upstream flop). This block adds no metastability stage.

## Configuration
- Macro: `D_DEBOUNCE_EDGE_COUNT_EN`.
- Defined: the saturating `edge_count` register is implemented as described above.
- Undefined: no counter is instantiated and `edge_count` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `d_debounce_pkg`:
  - state enum `deb_state_t` (`ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`);
  - localparam `DEB_MIN_STABLE`=2, for the parameter check.
- One sub-module: `sat_counter`, parameterised width, with `clk`/`rst`/`inc`/`count`. It is instantiated for `edge_count` only under `D_DEBOUNCE_EDGE_COUNT_EN`.
- The FSM and `run_cnt` live in the top module.

## Test plan
All scenarios use a 10 ns clock and STABLE_CYCLES=4.
- Reset: hold `rst`=1 for 2 cycles with `d_in`=1 → `q_stable`=0, `rise`=0, `fall`=0, `edge_count`=0 throughout. Then release `rst` → `rise` is seen 4 edges later.
- Clean rise: `d_in` 0→1 held 6 cycles → `q_stable`=1 and `rise`=1 for exactly one cycle, on the 4th sampling edge; `edge_count`=1.
- Glitch reject: `d_in`=1 for 3 cycles, then 0 → `q_stable` stays 0, no `rise`, `edge_count`=0.
- Clean fall after high: from `q_stable`=1, `d_in`=0 held 5 cycles → `fall` pulses once on the 4th edge; `q_stable`=0; `edge_count` unchanged.
- Reset mid-check: `d_in`=1, assert `rst` on the 3rd sample → no `rise`. After release with `d_in` still 1, acceptance needs a full 4 new samples.
- Saturation (CNT_W=2, macro defined): 5 accepted rising edges → `edge_count` reads 1, 2, 3, 3, 3. `rise` pulses all 5 times.

Source files
------------

// File: rtl/d_debounce_pkg.sv
// Shared types for the d_debounce_edge debounce / edge-detect stage.
// Holds the FSM state enum and the minimum legal stable-cycle count.
package d_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    CHK_HIGH,
    ST_HIGH,
    CHK_LOW
  } deb_state_t;

  localparam int DEB_MIN_STABLE = 2;

endpackage

// File: rtl/d_debounce_edge_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones; reset wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/d_debounce_edge.sv
// Debounce filter with registered rise/fall strobes for a synchronous level.
// Define D_DEBOUNCE_EDGE_COUNT_EN to build the saturating rising-edge counter.
module d_debounce_edge
  import d_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  output logic             q_stable,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] ONE  = RW'(1);
  localparam logic [RW-1:0] LAST = RW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < DEB_MIN_STABLE) begin : g_bad_param
    $error("d_debounce_edge: STABLE_CYCLES below minimum");
  end

  deb_state_t    state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          q_q, q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      run_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      ST_LOW: begin
        if (d_in) begin
          state_d = CHK_HIGH;
          run_d   = ONE;
        end
      end
      CHK_HIGH: begin
        if (!d_in) begin
          state_d = ST_LOW;
          run_d   = '0;
        end else if (run_q == LAST) begin
          state_d = ST_HIGH;
          run_d   = '0;
        end else begin
          run_d   = run_q + ONE;
        end
      end
      ST_HIGH: begin
        if (!d_in) begin
          state_d = CHK_LOW;
          run_d   = ONE;
        end
      end
      CHK_LOW: begin
        if (d_in) begin
          state_d = ST_HIGH;
          run_d   = '0;
        end else if (run_q == LAST) begin
          state_d = ST_LOW;
          run_d   = '0;
        end else begin
          run_d   = run_q + ONE;
        end
      end
    endcase
  end

  // Strobes fire on the sample that completes a check.
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    q_d    = q_q;
    unique case (1'b1)
      (state_q == CHK_HIGH) && d_in && (run_q == LAST): begin
        rise_d = 1'b1;
        q_d    = 1'b1;
      end
      (state_q == CHK_LOW) && !d_in && (run_q == LAST): begin
        fall_d = 1'b1;
        q_d    = 1'b0;
      end
      default: ;
    endcase
  end

  assign q_stable = q_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

`ifdef D_DEBOUNCE_EDGE_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_edge_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (rise_d),
    .count(edge_count)
  );
`else
  assign edge_count = '0;
`endif

endmodule
